if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch initiator that drives the byte address into the combinational, little-endian instruction memory.
- Captures the returned 32-bit word into an IF/ID output register with a valid/ready handshake toward decode.
- Owns the PC: sequential +4 advance, redirect from execute/branch, misaligned-target fault handling.
- The memory is combinational, so the word for iaddr_o is sampled in the same cycle it is addressed.

Parameters:
- ADDR_W, 32, width of PC and instruction address.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, word presented on a fault beat (addi x0,x0,0).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_n_i  input  1  reset: synchronous, active-low.
- iaddr_o  output  ADDR_W  fetch address to instruction memory; equals pc_r (combinational from register).
- instr_i  input  32  word returned by instruction memory for iaddr_o, same cycle.
- redirect_i  input  1  load new PC, kill the in-flight beat.
- redirect_pc_i  input  ADDR_W  redirect target.
- valid_o  output  1  IF/ID beat valid.
- ready_i  input  1  decode accepts the beat.
- instr_o  output  32  registered instruction.
- pc_o  output  ADDR_W  PC of instr_o.
- fault_o  output  1  beat is an instruction-address-misaligned fault.
- fetch_cnt_o  output  32  count of accepted beats (valid_o && ready_i), wraps.

Behaviour:
- Reset (rst_n_i==0 at edge): pc_r=RESET_PC, valid_o=0, instr_o=0, pc_o=0, fault_o=0, fetch_cnt_o=0, state=S_RUN. Reset mid-beat discards the beat.
- fire = (!valid_o || ready_i) && state==S_RUN && !redirect_i.
- On fire, the same edge performs:
  - instr_o<=instr_i, pc_o<=pc_r, fault_o<=0, valid_o<=1.
  - pc_r<=pc_r+4, modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0 with no flag.
  - Latency: address to beat is 1 cycle. Sustained throughput is 1 beat/cycle while ready_i=1.
- When valid_o && !ready_i: instr_o, pc_o and fault_o are held stable, and pc_r is held.
- When !fire and no redirect, and the beat was consumed or never existed: valid_o<=0.
- Redirect has priority over everything except reset. At the redirect edge:
  - valid_o<=0 (kill).
  - pc_r<=redirect_pc_i.
  - If redirect_pc_i[1:0]==0, state<=S_RUN. Otherwise state<=S_FAULT.
- fetch_cnt_o increments on every cycle with valid_o && ready_i, including a cycle coinciding with redirect.
- FSM:
  - S_RUN: normal fetch as above.
  - S_FAULT: if the output is free, emit one beat: valid_o<=1, fault_o<=1, instr_o<=NOP_INSTR, pc_o<=pc_r. Then state<=S_HALT. pc_r is not advanced, and memory data is ignored.
  - S_HALT: no beats issued. iaddr_o still shows pc_r, but the data is ignored. Leaves only via redirect: aligned target goes to S_RUN, misaligned to S_FAULT.
- A redirect in S_FAULT before the fault beat is emitted cancels the fault. A redirect arriving while the fault beat is pending in the output register kills that beat.
- Back-to-back redirects: the last one wins, and each kills the output.

Decomposition:
- Package if_pkg holds:
  - ADDR_W, INSTR_W=32.
  - RESET_PC, NOP_INSTR.
  - Fetch FSM state encoding (S_RUN=2'd0, S_FAULT=2'd1, S_HALT=2'd2).
  - PC increment constant 4.
- One natural sub-module, if_pipe_reg: the valid/ready output register holding {instr, pc, fault}, with load/kill/hold controls.
- PC and FSM stay in if_fetch.

Test Plan:
- Reset then ready_i=1 with memory = {0x0,0x4,0x8} -> beats with pc_o 0x0, 0x4, 0x8 on consecutive cycles. First valid_o is 1 cycle after reset release, and fetch_cnt_o reaches 3.
- ready_i=0 for 3 cycles mid-stream -> pc_o=0x4 and instr_o held stable, iaddr_o held at 0x8, no duplicate or lost beat after ready_i returns.
- redirect_i=1 with redirect_pc_i=0x100 while a beat is stalled -> valid_o=0 next cycle. The next beat has pc_o=0x100 and instr_o=mem word at 0x100.
- redirect_pc_i=0x102 -> one beat with fault_o=1, pc_o=0x102, instr_o=0x00000013, then valid_o stays 0. A later redirect to 0x200 resumes with pc_o=0x200.
- Start with RESET_PC=32'hFFFF_FFF8 -> pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, no fault.
- Reset asserted while valid_o=1 and ready_i=0 -> next cycle valid_o=0, fetch_cnt_o=0, and iaddr_o=RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [ADDR_W-1:0]  PC_INC    = 32'd4;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FAULT = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_e;

    // A fetch target is legal only on a 4-byte boundary.
    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: instruction-memory port, redirect input, IF/ID handshake.
interface if_fetch_if #(
    parameter int unsigned ADDR_W = if_pkg::ADDR_W
);
    logic [ADDR_W-1:0]          iaddr_o;
    logic [if_pkg::INSTR_W-1:0] instr_i;
    logic                       redirect_i;
    logic [ADDR_W-1:0]          redirect_pc_i;
    logic                       valid_o;
    logic                       ready_i;
    logic [if_pkg::INSTR_W-1:0] instr_o;
    logic [ADDR_W-1:0]          pc_o;
    logic                       fault_o;
    logic [31:0]                fetch_cnt_o;

    modport master (
        output iaddr_o, valid_o, instr_o, pc_o, fault_o, fetch_cnt_o,
        input  instr_i, redirect_i, redirect_pc_i, ready_i
    );

    modport slave (
        input  iaddr_o, valid_o, instr_o, pc_o, fault_o, fetch_cnt_o,
        output instr_i, redirect_i, redirect_pc_i, ready_i
    );
endinterface

// File: rtl/if_pipe_reg.sv
// IF/ID output register: holds {instr, pc, fault} under a valid/ready handshake.
module if_pipe_reg #(
    parameter int unsigned ADDR_W  = if_pkg::ADDR_W,
    parameter int unsigned INSTR_W = if_pkg::INSTR_W
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               i_load,
    input  logic               i_kill,
    input  logic               i_ready,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc,
    input  logic               i_fault,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_fault
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_fault;

    // Kill beats load; without a load a consumed beat drops valid, a stalled one holds.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
            r_fault <= 1'b0;
        end else if (i_kill) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_fault <= i_fault;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_fault = r_fault;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC ownership, redirect/fault FSM, IF/ID beat issue.
module if_fetch
    import if_pkg::*;
#(
    parameter int unsigned       ADDR_W    = if_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = if_pkg::RESET_PC,
    parameter logic [31:0]       NOP_INSTR = if_pkg::NOP_INSTR
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    if_fetch_if.master bus
);

    logic [ADDR_W-1:0]  r_pc;
    fetch_state_e       r_state;
    logic [31:0]        r_fetch_cnt;

    logic               w_valid;
    logic               w_free;
    logic               w_run_fire;
    logic               w_fault_fire;
    logic               w_load;
    logic [INSTR_W-1:0] w_load_instr;

    assign w_free       = !w_valid || bus.ready_i;
    assign w_run_fire   = w_free && (r_state == S_RUN)   && !bus.redirect_i;
    assign w_fault_fire = w_free && (r_state == S_FAULT) && !bus.redirect_i;
    assign w_load       = w_run_fire || w_fault_fire;
    assign w_load_instr = w_fault_fire ? NOP_INSTR : bus.instr_i;

    // PC and fetch FSM; redirect overrides every state.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_pc    <= RESET_PC;
            r_state <= S_RUN;
        end else if (bus.redirect_i) begin
            r_pc    <= bus.redirect_pc_i;
            r_state <= is_aligned(bus.redirect_pc_i[1:0]) ? S_RUN : S_FAULT;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_run_fire) begin
                        r_pc <= r_pc + ADDR_W'(PC_INC);
                    end
                end
                S_FAULT: begin
                    if (w_fault_fire) begin
                        r_state <= S_HALT;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    // Accepted-beat counter, counts even on a redirect cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_fetch_cnt <= '0;
        end else if (w_valid && bus.ready_i) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    if_pipe_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_pipe (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_load  (w_load),
        .i_kill  (bus.redirect_i),
        .i_ready (bus.ready_i),
        .i_instr (w_load_instr),
        .i_pc    (r_pc),
        .i_fault (w_fault_fire),
        .o_valid (w_valid),
        .o_instr (bus.instr_o),
        .o_pc    (bus.pc_o),
        .o_fault (bus.fault_o)
    );

    assign bus.iaddr_o     = r_pc;
    assign bus.valid_o     = w_valid;
    assign bus.fetch_cnt_o = r_fetch_cnt;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: vector table plus a PC wrap-around sequence.
module tb_if_fetch;

    logic clk;
    logic rst_a;
    logic rst_b;

    int unsigned n_checks;
    int unsigned n_fails;

    if_fetch_if #(.ADDR_W(32)) bus_a ();
    if_fetch_if #(.ADDR_W(32)) bus_b ();

    if_fetch #(
        .ADDR_W    (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut_a (
        .clk_i   (clk),
        .rst_n_i (rst_a),
        .bus     (bus_a.master)
    );

    if_fetch #(
        .ADDR_W    (32),
        .RESET_PC  (32'hFFFF_FFF8),
        .NOP_INSTR (32'h0000_0013)
    ) dut_b (
        .clk_i   (clk),
        .rst_n_i (rst_b),
        .bus     (bus_b.master)
    );

    // Memory contents: upper half = ~addr[15:0], lower half = addr[15:0].
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign bus_a.instr_i = memf(bus_a.iaddr_o);
    assign bus_b.instr_i = memf(bus_b.iaddr_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_fault;
        logic [31:0] e_iaddr;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.ready_i = 1'b0;
        bus_a.redirect_i = 1'b0;
        bus_a.redirect_pc_i = '0;
        bus_b.ready_i = 1'b1;
        bus_b.redirect_i = 1'b0;
        bus_b.redirect_pc_i = '0;

        //           rst rdy rd  rpc            v   pc             instr          f   iaddr          cnt
        vecs[0]  = '{1'b0,1'b1,1'b0,32'h0,     1'b0,32'h0,     32'h0,         1'b0,32'h0,     32'd0};
        vecs[1]  = '{1'b1,1'b1,1'b0,32'h0,     1'b1,32'h0,     32'hFFFF_0000, 1'b0,32'h4,     32'd0};
        vecs[2]  = '{1'b1,1'b1,1'b0,32'h0,     1'b1,32'h4,     32'hFFFB_0004, 1'b0,32'h8,     32'd1};
        vecs[3]  = '{1'b1,1'b0,1'b0,32'h0,     1'b1,32'h4,     32'hFFFB_0004, 1'b0,32'h8,     32'd1};
        vecs[4]  = '{1'b1,1'b0,1'b0,32'h0,     1'b1,32'h4,     32'hFFFB_0004, 1'b0,32'h8,     32'd1};
        vecs[5]  = '{1'b1,1'b0,1'b0,32'h0,     1'b1,32'h4,     32'hFFFB_0004, 1'b0,32'h8,     32'd1};
        vecs[6]  = '{1'b1,1'b1,1'b0,32'h0,     1'b1,32'h8,     32'hFFF7_0008, 1'b0,32'hC,     32'd2};
        vecs[7]  = '{1'b1,1'b1,1'b0,32'h0,     1'b1,32'hC,     32'hFFF3_000C, 1'b0,32'h10,    32'd3};
        vecs[8]  = '{1'b1,1'b0,1'b0,32'h0,     1'b1,32'hC,     32'hFFF3_000C, 1'b0,32'h10,    32'd3};
        vecs[9]  = '{1'b1,1'b0,1'b1,32'h100,   1'b0,32'h0,     32'h0,         1'b0,32'h100,   32'd3};
        vecs[10] = '{1'b1,1'b1,1'b0,32'h0,     1'b1,32'h100,   32'hFEFF_0100, 1'b0,32'h104,   32'd3};
        vecs[11] = '{1'b1,1'b1,1'b1,32'h102,   1'b0,32'h0,     32'h0,         1'b0,32'h102,   32'd4};
        vecs[12] = '{1'b1,1'b1,1'b0,32'h0,     1'b1,32'h102,   32'h0000_0013, 1'b1,32'h102,   32'd4};
        vecs[13] = '{1'b1,1'b1,1'b0,32'h0,     1'b0,32'h0,     32'h0,         1'b0,32'h102,   32'd5};
        vecs[14] = '{1'b1,1'b1,1'b0,32'h0,     1'b0,32'h0,     32'h0,         1'b0,32'h102,   32'd5};
        vecs[15] = '{1'b1,1'b1,1'b1,32'h200,   1'b0,32'h0,     32'h0,         1'b0,32'h200,   32'd5};
        vecs[16] = '{1'b1,1'b1,1'b0,32'h0,     1'b1,32'h200,   32'hFDFF_0200, 1'b0,32'h204,   32'd5};
        vecs[17] = '{1'b1,1'b1,1'b0,32'h0,     1'b1,32'h204,   32'hFDFB_0204, 1'b0,32'h208,   32'd6};
        vecs[18] = '{1'b1,1'b0,1'b0,32'h0,     1'b1,32'h204,   32'hFDFB_0204, 1'b0,32'h208,   32'd6};
        vecs[19] = '{1'b0,1'b0,1'b0,32'h0,     1'b0,32'h0,     32'h0,         1'b0,32'h0,     32'd0};
        vecs[20] = '{1'b1,1'b1,1'b0,32'h0,     1'b1,32'h0,     32'hFFFF_0000, 1'b0,32'h4,     32'd0};
        vecs[21] = '{1'b1,1'b0,1'b1,32'h302,   1'b0,32'h0,     32'h0,         1'b0,32'h302,   32'd0};
        vecs[22] = '{1'b1,1'b0,1'b0,32'h0,     1'b1,32'h302,   32'h0000_0013, 1'b1,32'h302,   32'd0};
        vecs[23] = '{1'b1,1'b0,1'b1,32'h300,   1'b0,32'h0,     32'h0,         1'b0,32'h300,   32'd0};
        vecs[24] = '{1'b1,1'b0,1'b0,32'h0,     1'b1,32'h300,   32'hFCFF_0300, 1'b0,32'h304,   32'd0};
        vecs[25] = '{1'b1,1'b0,1'b1,32'h401,   1'b0,32'h0,     32'h0,         1'b0,32'h401,   32'd0};
        vecs[26] = '{1'b1,1'b0,1'b1,32'h500,   1'b0,32'h0,     32'h0,         1'b0,32'h500,   32'd0};
        vecs[27] = '{1'b1,1'b1,1'b0,32'h0,     1'b1,32'h500,   32'hFAFF_0500, 1'b0,32'h504,   32'd0};

        // Vector table on instance A (RESET_PC = 0).
        for (int i = 0; i < NV; i++) begin
            rst_a               = vecs[i].rst_n;
            bus_a.ready_i       = vecs[i].ready;
            bus_a.redirect_i    = vecs[i].redir;
            bus_a.redirect_pc_i = vecs[i].rpc;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid", i), {31'd0, bus_a.valid_o}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d iaddr", i), bus_a.iaddr_o, vecs[i].e_iaddr);
            chk($sformatf("v%0d cnt", i), bus_a.fetch_cnt_o, vecs[i].e_cnt);
            if (vecs[i].e_valid || !vecs[i].rst_n) begin
                chk($sformatf("v%0d pc", i), bus_a.pc_o, vecs[i].e_pc);
                chk($sformatf("v%0d instr", i), bus_a.instr_o, vecs[i].e_instr);
                chk($sformatf("v%0d fault", i), {31'd0, bus_a.fault_o}, {31'd0, vecs[i].e_fault});
            end
        end
        bus_a.ready_i    = 1'b1;
        bus_a.redirect_i = 1'b0;

        // Instance B: PC wraps from FFFF_FFFC to 0 with no fault.
        chk("wrap reset iaddr", bus_b.iaddr_o, 32'hFFFF_FFF8);
        chk("wrap reset valid", {31'd0, bus_b.valid_o}, 32'd0);
        rst_b = 1'b1;
        @(posedge clk); #1;
        chk("wrap b1 pc", bus_b.pc_o, 32'hFFFF_FFF8);
        chk("wrap b1 instr", bus_b.instr_o, 32'h0007_FFF8);
        chk("wrap b1 iaddr", bus_b.iaddr_o, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        chk("wrap b2 pc", bus_b.pc_o, 32'hFFFF_FFFC);
        chk("wrap b2 instr", bus_b.instr_o, 32'h0003_FFFC);
        chk("wrap b2 iaddr", bus_b.iaddr_o, 32'h0000_0000);
        @(posedge clk); #1;
        chk("wrap b3 pc", bus_b.pc_o, 32'h0000_0000);
        chk("wrap b3 instr", bus_b.instr_o, 32'hFFFF_0000);
        chk("wrap b3 fault", {31'd0, bus_b.fault_o}, 32'd0);
        chk("wrap b3 valid", {31'd0, bus_b.valid_o}, 32'd1);
        chk("wrap b3 cnt", bus_b.fetch_cnt_o, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
